// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the two-port main-memory arbiter.
//   arb_state_t : transaction sequencer states (IDLE -> BUSY -> RESP)
//   arb_port_t  : requester identity (instruction fetch / data cache)
//   pickGrant   : fixed arbitration rule used in the IDLE state
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // A lone requester always wins; on a tie the port that did not win last
    // time is chosen, so two continuous requesters strictly alternate.
    function automatic arb_port_t pickGrant(input logic iReq,
                                            input logic dReq,
                                            input arb_port_t lastGrant);
        if (iReq && dReq) begin
            return (lastGrant == PORT_I) ? PORT_D : PORT_I;
        end
        return dReq ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// -----------------------------------------------------------------------------
// mem_arb_stats
// Free-running 32-bit event counters for the arbiter (wrap at 2^32).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (counters -> 0)
//   grantI        : one-cycle strobe, a grant was issued to the I port
//   grantD        : one-cycle strobe, a grant was issued to the D port
//   conflict      : one-cycle strobe, both ports requested in an IDLE cycle
//   grant_i_cnt   : number of I grants
//   grant_d_cnt   : number of D grants
//   conflict_cnt  : number of conflicting IDLE cycles
// -----------------------------------------------------------------------------
module mem_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        grantI,
    input  logic        grantD,
    input  logic        conflict,
    output logic [31:0] grant_i_cnt,
    output logic [31:0] grant_d_cnt,
    output logic [31:0] conflict_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_i_cnt  <= '0;
            grant_d_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            // Natural 32-bit overflow gives the required wrap-around.
            if (grantI)   grant_i_cnt  <= grant_i_cnt + 32'd1;
            if (grantD)   grant_d_cnt  <= grant_d_cnt + 32'd1;
            if (conflict) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single line-wide datamem port between the instruction-fetch line
// requester (I, read only) and the data-cache refill/writeback requester
// (D, read/write). One transaction at a time: IDLE -> BUSY -> RESP -> IDLE.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_req/i_addr    : I line read request (held until i_ready) and address
//   i_ready/i_rdata : one-cycle completion pulse, registered read line
//   d_req/d_we      : D request (held until d_ready), 1 = write line
//   d_addr/d_wdata  : D line address and write line
//   d_ready/d_rdata : one-cycle completion pulse, registered read line
//   mem_req         : datamem request, high for the whole BUSY phase
//   WriteEnable     : datamem write strobe, valid with mem_req
//   memory_address  : datamem address, valid with mem_req
//   mem_writedata   : datamem write line
//   mem_readdata    : datamem read line, valid with mem_ready
//   mem_ready       : datamem completion strobe (ignored outside BUSY)
//
// Build option: define MEM_ARB_STATS_EN to add grant_i_cnt, grant_d_cnt and
// conflict_cnt outputs (mem_arb_stats). Arbitration is identical either way.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [LINE_WIDTH-1:0] mem_writedata,
    input  logic [LINE_WIDTH-1:0] mem_readdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]           grant_i_cnt,
    output logic [31:0]           grant_d_cnt,
    output logic [31:0]           conflict_cnt,
`endif
    input  logic                  mem_ready
);

    arb_state_t            state;
    arb_port_t             lastGrant;
    arb_port_t             grantPort;
    arb_port_t             nextGrant;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic                  weReg;
    logic [LINE_WIDTH-1:0] wdataReg;
    logic                  anyReq;

    assign anyReq    = i_req || d_req;
    assign nextGrant = pickGrant(i_req, d_req, lastGrant);

    // NOTE: every register here updates with <= so all of them see the
    // pre-edge values of each other; blocking assignments would make the
    // result depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched request and the returned lines are reset too,
            // because they drive ports that must read 0 out of reset and must
            // never carry X into the caches.
            state     <= IDLE;
            lastGrant <= PORT_I;
            grantPort <= PORT_I;
            addrReg   <= '0;
            weReg     <= 1'b0;
            wdataReg  <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grantPort <= nextGrant;
                        lastGrant <= nextGrant;
                        // Snapshot the winner's request; requester inputs are
                        // ignored until the transaction completes.
                        if (nextGrant == PORT_D) begin
                            addrReg  <= d_addr;
                            weReg    <= d_we;
                            wdataReg <= d_wdata;
                        end else begin
                            addrReg  <= i_addr;
                            weReg    <= 1'b0;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        // Only the granted port's line changes, and a D write
                        // leaves d_rdata untouched.
                        if (grantPort == PORT_I) begin
                            i_rdata <= mem_readdata;
                        end else if (!weReg) begin
                            d_rdata <= mem_readdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so mem_req falls the moment
    // reset is asserted, with no extra cycle of request.
    assign mem_req        = (state == BUSY);
    assign WriteEnable    = (state == BUSY) && weReg;
    assign memory_address = addrReg;
    assign mem_writedata  = wdataReg;
    assign i_ready        = (state == RESP) && (grantPort == PORT_I);
    assign d_ready        = (state == RESP) && (grantPort == PORT_D);

`ifdef MEM_ARB_STATS_EN
    logic grantEvent;
    logic conflictEvent;

    assign grantEvent    = (state == IDLE) && anyReq;
    assign conflictEvent = (state == IDLE) && i_req && d_req;

    mem_arb_stats uStats (
        .clk          (clk),
        .rst          (rst),
        .grantI       (grantEvent && (nextGrant == PORT_I)),
        .grantD       (grantEvent && (nextGrant == PORT_D)),
        .conflict     (conflictEvent),
        .grant_i_cnt  (grant_i_cnt),
        .grant_d_cnt  (grant_d_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. A transaction-level reference model predicts
// the memory-side request, ready pulses and returned lines every cycle; a few
// literal expectations pin the model's arbitration order and data.
// Build option MEM_ARB_STATS_EN also checks the statistics counters.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic [LW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [LW-1:0] d_rdata;
    logic          mem_req;
    logic          WriteEnable;
    logic [AW-1:0] memory_address;
    logic [LW-1:0] mem_writedata;
    logic [LW-1:0] mem_readdata = '0;
    logic          mem_ready = 1'b0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   grant_i_cnt;
    logic [31:0]   grant_d_cnt;
    logic [31:0]   conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ready        (i_ready),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ready        (d_ready),
        .d_rdata        (d_rdata),
        .mem_req        (mem_req),
        .WriteEnable    (WriteEnable),
        .memory_address (memory_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
`ifdef MEM_ARB_STATS_EN
        .grant_i_cnt    (grant_i_cnt),
        .grant_d_cnt    (grant_d_cnt),
        .conflict_cnt   (conflict_cnt),
`endif
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- datamem model ----------------
    // Reads return a line derived from the address; 0x1000 returns A5..A5.
    // A write cycle returns a junk line the arbiter must not capture.
    function automatic logic [LW-1:0] rdataFor(input logic [AW-1:0] addr, input logic we);
        if (we)                  return {4{32'hFFFF_0000}};
        if (addr == 32'h1000)    return {16{8'hA5}};
        return {4{addr ^ 32'h5A5A_0000}};
    endfunction

    int   memDelay = 2;
    int   waitCnt = 0;
    logic strayReady = 1'b0;

    always @(negedge clk) begin
        if (mem_req && !rst) begin
            if (waitCnt >= memDelay) begin
                mem_ready    = 1'b1;
                mem_readdata = rdataFor(memory_address, WriteEnable);
                waitCnt      = 0;
            end else begin
                mem_ready = 1'b0;
                waitCnt++;
            end
        end else begin
            mem_ready = strayReady;
            if (strayReady) mem_readdata = {4{32'hBAD0_BAD0}};
            waitCnt = 0;
        end
    end

    // ---------------- reference model ----------------
    // phase: 0 = free to accept a request, 1 = memory operation outstanding,
    //        2 = completion cycle for the granted requester.
    int            phase = 0;
    bit            lastWasD = 1'b0;
    bit            curIsD = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic          mWe = 1'b0;
    logic [LW-1:0] mWdata = '0;
    logic [LW-1:0] expIRdata = '0;
    logic [LW-1:0] expDRdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     = 0;
            lastWasD  = 1'b0;
            expIRdata = '0;
            expDRdata = '0;
        end else begin
            if (phase == 0) begin
                if (i_req || d_req) begin
                    if (i_req && d_req) curIsD = !lastWasD;
                    else                curIsD = d_req;
                    lastWasD = curIsD;
                    mAddr    = curIsD ? d_addr : i_addr;
                    mWe      = curIsD ? d_we : 1'b0;
                    mWdata   = d_wdata;
                    phase    = 1;
                end
            end else if (phase == 1) begin
                if (mem_ready) begin
                    if (!curIsD)   expIRdata = mem_readdata;
                    else if (!mWe) expDRdata = mem_readdata;
                    phase = 2;
                end
            end else begin
                phase = 0;
            end
        end
    end

    bit cmpEn = 1'b0;

    always @(negedge clk) begin
        if (cmpEn) begin
            check("mem_req", mem_req, phase == 1);
            if (phase == 1) begin
                check("memory_address", memory_address, mAddr);
                check("WriteEnable", WriteEnable, mWe);
                if (mWe) check("mem_writedata", mem_writedata, mWdata);
            end
            check("i_ready", i_ready, (phase == 2) && !curIsD);
            check("d_ready", d_ready, (phase == 2) && curIsD);
            check("i_rdata", i_rdata, expIRdata);
            check("d_rdata", d_rdata, expDRdata);
        end
    end

    // ---------------- observation of the DUT ----------------
    byte           readyLog[$];
    int            logBase = 0;
    logic [AW-1:0] lastAddr = '0;
    logic          lastWe = 1'b0;
    logic [LW-1:0] lastWdata = '0;

    always @(negedge clk) begin
        if (i_ready) readyLog.push_back(8'h49);  // 'I'
        if (d_ready) readyLog.push_back(8'h44);  // 'D'
        if (mem_req) begin
            lastAddr  = memory_address;
            lastWe    = WriteEnable;
            lastWdata = mem_writedata;
        end
    end

    function automatic int logLen();
        return readyLog.size() - logBase;
    endfunction

    function automatic byte logAt(input int k);
        if (logBase + k < readyLog.size()) return readyLog[logBase + k];
        return 8'h3F;  // '?'
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitLog(input int target, input int budget, input string name);
        int n = 0;
        while (logLen() < target && n < budget) begin
            tick();
            n++;
        end
        check(name, logLen() >= target, 1'b1);
    endtask

    task automatic waitMemReq(input int budget, input string name);
        int n = 0;
        while (!mem_req && n < budget) begin
            tick();
            n++;
        end
        check(name, mem_req, 1'b1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick();
        tick();
        // Reset state
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_we", WriteEnable, 1'b0);
        check("rst_addr", memory_address, '0);
        check("rst_i_ready", i_ready, 1'b0);
        check("rst_d_ready", d_ready, 1'b0);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
`ifdef MEM_ARB_STATS_EN
        check("rst_grant_i_cnt", grant_i_cnt, '0);
        check("rst_conflict_cnt", conflict_cnt, '0);
`endif
        cmpEn = 1'b1;
        rst   = 1'b0;
        tick();

        // 1: I-only line read
        logBase = readyLog.size();
        i_addr  = 32'h0000_1000;
        i_req   = 1'b1;
        waitLog(1, 30, "t1_ready_seen");
        i_req = 1'b0;
        check("t1_addr", lastAddr, 32'h1000);
        check("t1_we", lastWe, 1'b0);
        check("t1_i_rdata", i_rdata, {16{8'hA5}});
        tick();
        tick();
        check("t1_ready_count", logLen(), 1);
        check("t1_ready_port", logAt(0), 8'h49);

        // Stray mem_ready while idle must not disturb anything
        strayReady = 1'b1;
        tick();
        strayReady = 1'b0;
        tick();
        tick();
        check("stray_i_rdata", i_rdata, {16{8'hA5}});
        check("stray_no_ready", logLen(), 1);

        // 4: D read with address churn while BUSY
        memDelay = 4;
        logBase  = readyLog.size();
        d_we     = 1'b0;
        d_addr   = 32'h100;
        d_req    = 1'b1;
        waitMemReq(10, "t4_mem_req");
        d_addr  = 32'h200;
        d_wdata = {4{32'h1234_5678}};
        tick();
        tick();
        check("t4_churn_mem_req", mem_req, 1'b1);
        check("t4_churn_addr", memory_address, 32'h100);
        waitLog(1, 30, "t4_ready_seen");
        d_req = 1'b0;
        check("t4_d_rdata", d_rdata, {4{32'h5A5A_0100}});
        memDelay = 2;
        tick();

        // 2: D line write; d_rdata must keep the previous read line
        logBase = readyLog.size();
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = {4{32'hDEAD_BEEF}};
        d_req   = 1'b1;
        waitLog(1, 30, "t2_ready_seen");
        d_req = 1'b0;
        d_we  = 1'b0;
        check("t2_we", lastWe, 1'b1);
        check("t2_addr", lastAddr, 32'h100);
        check("t2_wdata", lastWdata, {4{32'hDEAD_BEEF}});
        check("t2_ready_port", logAt(0), 8'h44);
        check("t2_d_rdata_held", d_rdata, {4{32'h5A5A_0100}});
        tick();

        // 3: tie after reset, both requesting continuously -> D,I,D,I
        pulseReset();
        logBase = readyLog.size();
        i_addr  = 32'h2000;
        d_addr  = 32'h3000;
        i_req   = 1'b1;
        d_req   = 1'b1;
        waitLog(4, 60, "t3_four_grants");
        i_req = 1'b0;
        d_req = 1'b0;
        check("t3_order0", logAt(0), 8'h44);
        check("t3_order1", logAt(1), 8'h49);
        check("t3_order2", logAt(2), 8'h44);
        check("t3_order3", logAt(3), 8'h49);
        check("t3_i_rdata", i_rdata, {4{32'h5A5A_2000}});
        check("t3_d_rdata", d_rdata, {4{32'h5A5A_3000}});
        tick();
        tick();
`ifdef MEM_ARB_STATS_EN
        // 6: statistics after the four tied grants
        check("t6_grant_i_cnt", grant_i_cnt, 32'd2);
        check("t6_grant_d_cnt", grant_d_cnt, 32'd2);
        check("t6_conflict_cnt", conflict_cnt, 32'd4);
`endif

        // 5: reset while BUSY
        logBase = readyLog.size();
        d_addr  = 32'h300;
        d_req   = 1'b1;
        waitMemReq(10, "t5_mem_req");
        rst = 1'b1;
        #1;
        check("t5_mem_req_async_drop", mem_req, 1'b0);
        tick();
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t5_no_ready", logLen(), 0);
        i_addr = 32'h4000;
        d_addr = 32'h5000;
        i_req  = 1'b1;
        d_req  = 1'b1;
        waitLog(1, 30, "t5_first_grant");
        d_req = 1'b0;
        check("t5_first_is_d", logAt(0), 8'h44);
        waitLog(2, 30, "t5_second_grant");
        i_req = 1'b0;
        check("t5_second_is_i", logAt(1), 8'h49);
        check("t5_i_rdata", i_rdata, {4{32'h5A5A_4000}});
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
